// File: rtl/bfp_stage_exponent_tracker.sv
`default_nettype none
// ============================================================================
// Module   : bfp_stage_exponent_tracker
// Brief    : Per-stage block-floating-point shift decision and block exponent
//            accumulation for a radix-2 FFT datapath.
// Revision : 1.0 - initial release
// ============================================================================

module bfp_stage_exponent_tracker #(
    parameter int FFT_MAX_BIT_WIDTH = 5,
    parameter int FFT_DW            = 16,
    parameter int FFT_N_LOG2        = 10,
    parameter int BFP_EXP_W         = 6,
    localparam int STAGE_W          = $clog2(FFT_N_LOG2 + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fft_start,
    input  logic                         bw_valid,
    input  logic [FFT_MAX_BIT_WIDTH-1:0] min_bit_width,
    input  logic                         stage_done,
    output logic [1:0]                   scale_shift,
    output logic                         shift_valid,
    output logic [BFP_EXP_W-1:0]         block_exp,
    output logic [STAGE_W-1:0]           stage_idx,
    output logic                         busy,
    output logic                         fft_done
);

    localparam logic [1:0] c_s_idle   = 2'd0;
    localparam logic [1:0] c_s_accum  = 2'd1;
    localparam logic [1:0] c_s_update = 2'd2;

    // Widths up to c_thresh leave enough headroom for a radix-2 butterfly.
    localparam int c_thresh = FFT_DW - 2;
    localparam logic [STAGE_W-1:0] c_n_stages = STAGE_W'(FFT_N_LOG2);

    logic [1:0]                   r_state;
    logic [1:0]                   w_next_state;
    logic [FFT_MAX_BIT_WIDTH-1:0] r_max_bw;
    logic [1:0]                   r_scale_shift;
    logic                         r_shift_valid;
    logic [BFP_EXP_W-1:0]         r_block_exp;
    logic [STAGE_W-1:0]           r_stage_idx;
    logic                         r_busy;
    logic                         r_fft_done;

    logic                         w_update;
    logic                         w_last;
    logic [1:0]                   w_shift;
    logic [STAGE_W-1:0]           w_idx_inc;
    logic [BFP_EXP_W:0]           w_exp_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_s_idle;
            r_max_bw      <= '0;
            r_scale_shift <= '0;
            r_shift_valid <= 1'b0;
            r_block_exp   <= '0;
            r_stage_idx   <= '0;
            r_busy        <= 1'b0;
            r_fft_done    <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_shift_valid <= w_update;
            r_fft_done    <= w_update && w_last;
            r_busy        <= (w_next_state != c_s_idle) || (w_update && w_last);
            if (fft_start) begin
                r_max_bw      <= '0;
                r_scale_shift <= '0;
                r_block_exp   <= '0;
                r_stage_idx   <= '0;
            end else begin
                case (r_state)
                    c_s_accum: begin
                        if (bw_valid && (min_bit_width > r_max_bw))
                            r_max_bw <= min_bit_width;
                    end
                    c_s_update: begin
                        // A sample arriving during the update opens the next stage.
                        r_max_bw      <= bw_valid ? min_bit_width : '0;
                        r_scale_shift <= w_shift;
                        r_block_exp   <= w_exp_sum[BFP_EXP_W] ? '1 : w_exp_sum[BFP_EXP_W-1:0];
                        r_stage_idx   <= w_idx_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (fft_start) begin
            w_next_state = c_s_accum;
        end else begin
            case (r_state)
                c_s_accum:  if (stage_done) w_next_state = c_s_update;
                c_s_update: w_next_state = w_last ? c_s_idle : c_s_accum;
                default:    w_next_state = c_s_idle;
            endcase
        end
    end

    always_comb begin
        w_update  = (r_state == c_s_update) && !fft_start;
        w_idx_inc = r_stage_idx + STAGE_W'(1);
        w_last    = (w_idx_inc == c_n_stages);
        if (int'(r_max_bw) >= c_thresh + 2)
            w_shift = 2'd2;
        else if (int'(r_max_bw) == c_thresh + 1)
            w_shift = 2'd1;
        else
            w_shift = 2'd0;
        w_exp_sum = {1'b0, r_block_exp} + (BFP_EXP_W + 1)'(w_shift);
    end

    assign scale_shift = r_scale_shift;
    assign shift_valid = r_shift_valid;
    assign block_exp   = r_block_exp;
    assign stage_idx   = r_stage_idx;
    assign busy        = r_busy;
    assign fft_done    = r_fft_done;

endmodule

`default_nettype wire

// File: tb/tb_bfp_stage_exponent_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_bfp_stage_exponent_tracker
// Brief    : Directed bench with a stage-level reference model and literal
//            expectations for bfp_stage_exponent_tracker.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_bfp_stage_exponent_tracker;

    localparam int MBW = 5;
    localparam int DW  = 16;
    localparam int NL  = 10;
    localparam int EW  = 6;
    localparam int SW  = $clog2(NL + 1);
    localparam int EXP_MAX = (1 << EW) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           fft_start = 1'b0;
    logic           bw_valid = 1'b0;
    logic [MBW-1:0] min_bit_width = '0;
    logic           stage_done = 1'b0;
    logic [1:0]     scale_shift;
    logic           shift_valid;
    logic [EW-1:0]  block_exp;
    logic [SW-1:0]  stage_idx;
    logic           busy;
    logic           fft_done;

    always #5 clk = ~clk;

    bfp_stage_exponent_tracker #(
        .FFT_MAX_BIT_WIDTH(MBW),
        .FFT_DW(DW),
        .FFT_N_LOG2(NL),
        .BFP_EXP_W(EW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fft_start(fft_start),
        .bw_valid(bw_valid),
        .min_bit_width(min_bit_width),
        .stage_done(stage_done),
        .scale_shift(scale_shift),
        .shift_valid(shift_valid),
        .block_exp(block_exp),
        .stage_idx(stage_idx),
        .busy(busy),
        .fft_done(fft_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a transform is a sequence of stages, each closing with
    // a shift chosen from the widest butterfly seen in it.
    bit m_valid = 1'b0;
    int m_phase = 0;   // 0 idle, 1 collecting a stage, 2 closing a stage
    int m_max = 0, m_exp = 0, m_idx = 0, m_shift = 0;
    int m_sv = 0, m_done = 0, m_busy = 0;

    function automatic int shift_of(input int w);
        if (w <= DW - 2)      return 0;
        else if (w == DW - 1) return 1;
        else                  return 2;
    endfunction

    always @(posedge clk) begin
        m_valid = 1'b1;
        if (rst) begin
            m_phase = 0; m_max = 0; m_exp = 0; m_idx = 0; m_shift = 0;
            m_sv = 0; m_done = 0; m_busy = 0;
        end else begin
            m_sv = 0;
            m_done = 0;
            if (fft_start) begin
                m_phase = 1; m_max = 0; m_exp = 0; m_idx = 0; m_shift = 0; m_busy = 1;
            end else if (m_phase == 1) begin
                if (bw_valid && int'(min_bit_width) > m_max) m_max = int'(min_bit_width);
                if (stage_done) m_phase = 2;
            end else if (m_phase == 2) begin
                m_shift = shift_of(m_max);
                m_exp = (m_exp + m_shift > EXP_MAX) ? EXP_MAX : m_exp + m_shift;
                m_idx = m_idx + 1;
                m_sv = 1;
                m_max = bw_valid ? int'(min_bit_width) : 0;
                if (m_idx == NL) begin
                    m_done = 1;
                    m_phase = 0;
                end else begin
                    m_phase = 1;
                end
            end else begin
                m_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model.scale_shift", int'(scale_shift), m_shift);
            chk("model.shift_valid", int'(shift_valid), m_sv);
            chk("model.block_exp",   int'(block_exp),   m_exp);
            chk("model.stage_idx",   int'(stage_idx),   m_idx);
            chk("model.busy",        int'(busy),        m_busy);
            chk("model.fft_done",    int'(fft_done),    m_done);
        end
    end

    bit count_en = 1'b0;
    int sv_cnt = 0, done_cnt = 0, done_at = 0;
    always @(negedge clk) begin
        if (count_en) begin
            if (shift_valid) sv_cnt++;
            if (fft_done) begin
                done_cnt++;
                done_at = sv_cnt;
            end
        end
    end

    task automatic drive(input bit st, input bit bv, input int w, input bit sd);
        @(negedge clk);
        fft_start     = st;
        bw_valid      = bv;
        min_bit_width = w[MBW-1:0];
        stage_done    = sd;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        settle();
        chk("reset.scale_shift", int'(scale_shift), 0);
        chk("reset.shift_valid", int'(shift_valid), 0);
        chk("reset.block_exp",   int'(block_exp),   0);
        chk("reset.stage_idx",   int'(stage_idx),   0);
        chk("reset.busy",        int'(busy),        0);
        chk("reset.fft_done",    int'(fft_done),    0);
        rst = 1'b0;

        // Stage with widths 3, 14, 7 -> no shift
        drive(1, 0, 0, 0);
        drive(0, 1, 3, 0);
        drive(0, 1, 14, 0);
        drive(0, 1, 7, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        settle();
        chk("s1.shift_valid", int'(shift_valid), 1);
        chk("s1.scale_shift", int'(scale_shift), 0);
        chk("s1.block_exp",   int'(block_exp),   0);
        chk("s1.stage_idx",   int'(stage_idx),   1);

        // Widths 9, 15 -> shift 1; then 16 -> shift 2
        drive(0, 1, 9, 0);
        drive(0, 1, 15, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        settle();
        chk("s2.scale_shift", int'(scale_shift), 1);
        chk("s2.block_exp",   int'(block_exp),   1);
        drive(0, 1, 16, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        settle();
        chk("s3.scale_shift", int'(scale_shift), 2);
        chk("s3.block_exp",   int'(block_exp),   3);
        chk("s3.stage_idx",   int'(stage_idx),   3);

        // Width 16 coincident with stage_done; width 15 seeds during update
        drive(0, 1, 5, 0);
        drive(0, 1, 5, 0);
        drive(0, 1, 16, 1);
        drive(0, 1, 15, 0);
        drive(0, 0, 0, 1);
        chk("s4.shift_valid", int'(shift_valid), 1);
        chk("s4.scale_shift", int'(scale_shift), 2);
        chk("s4.block_exp",   int'(block_exp),   5);
        drive(0, 0, 0, 0);
        settle();
        chk("s5.scale_shift", int'(scale_shift), 1);
        chk("s5.block_exp",   int'(block_exp),   6);
        chk("s5.stage_idx",   int'(stage_idx),   5);

        // Finish the transform with narrow stages
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 10, 1);
            drive(0, 0, 0, 0);
            settle();
        end
        chk("t1.fft_done",  int'(fft_done),  1);
        chk("t1.block_exp", int'(block_exp), 6);
        chk("t1.stage_idx", int'(stage_idx), 10);
        chk("t1.busy",      int'(busy),      1);
        settle();
        chk("t1.busy_after", int'(busy),      0);
        chk("t1.exp_held",   int'(block_exp), 6);

        // Full transform, every stage at width 16
        drive(1, 0, 0, 0);
        count_en = 1'b1;
        for (int s = 0; s < NL; s++) begin
            drive(0, 1, 16, 1);
            drive(0, 0, 0, 0);
        end
        settle();
        chk("t2.fft_done",  int'(fft_done),  1);
        chk("t2.block_exp", int'(block_exp), 20);
        settle();
        count_en = 1'b0;
        chk("t2.busy_after", int'(busy), 0);
        chk("t2.sv_pulses",  sv_cnt,   10);
        chk("t2.done_with",  done_at,  10);
        chk("t2.done_count", done_cnt, 1);

        // Abort during the 4th stage update
        drive(1, 0, 0, 0);
        for (int s = 0; s < 3; s++) begin
            drive(0, 1, 16, 1);
            drive(0, 0, 0, 0);
        end
        drive(0, 1, 16, 1);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("ab.shift_valid", int'(shift_valid), 0);
        chk("ab.block_exp",   int'(block_exp),   0);
        chk("ab.stage_idx",   int'(stage_idx),   0);
        chk("ab.busy",        int'(busy),        1);
        drive(0, 1, 15, 1);
        drive(0, 0, 0, 0);
        settle();
        chk("ab.accum_shift", int'(scale_shift), 1);
        chk("ab.accum_exp",   int'(block_exp),   1);

        // fft_start overrides a coincident stage_done
        drive(1, 0, 0, 1);
        drive(0, 0, 0, 0);
        settle();
        chk("ov.shift_valid", int'(shift_valid), 0);
        chk("ov.stage_idx",   int'(stage_idx),   0);

        // Reset mid-stage with max 16
        drive(0, 1, 16, 0);
        drive(0, 0, 0, 0);
        rst = 1'b1;
        settle();
        chk("rst.scale_shift", int'(scale_shift), 0);
        chk("rst.block_exp",   int'(block_exp),   0);
        chk("rst.stage_idx",   int'(stage_idx),   0);
        chk("rst.busy",        int'(busy),        0);
        rst = 1'b0;

        // stage_done and bw_valid while idle are ignored
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        settle();
        chk("idle.shift_valid", int'(shift_valid), 0);
        chk("idle.busy",        int'(busy),        0);
        drive(0, 1, 16, 0);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        settle();
        chk("idle.bw_shift", int'(scale_shift), 0);
        chk("idle.bw_sv",    int'(shift_valid), 1);

        drive(0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bfp_stage_exponent_tracker.md
# bfp_stage_exponent_tracker

Sequential block-floating-point controller that sits directly downstream of the per-butterfly bit-width detector in the FFT datapath. It takes a running maximum of the detector's `min_bit_width` over every butterfly of one FFT stage. At each stage boundary it decides the right-shift (0, 1 or 2) to apply to the next stage's operands so they cannot overflow. It also accumulates the block exponent for the whole transform, which is reported to the spectrum/peak logic at the end of the FFT.

## Interface
- `FFT_MAX_BIT_WIDTH`, 5, width of the incoming `min_bit_width`.
- `FFT_DW`, 16, datapath word width; sets the headroom threshold.
- `FFT_N_LOG2`, 10, number of radix-2 stages per transform.
- `BFP_EXP_W`, 6, width of the accumulated block exponent.

- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fft_start`  in  1  one-cycle pulse; begins a new transform.
- `bw_valid`  in  1  `min_bit_width` is valid this cycle.
- `min_bit_width`  in  FFT_MAX_BIT_WIDTH  bit-width detector result for one butterfly.
- `stage_done`  in  1  one-cycle pulse; the current stage has issued its last butterfly.
- `scale_shift`  out  2  right-shift the datapath applies to the next stage's operands.
- `shift_valid`  out  1  one-cycle pulse; `scale_shift`/`block_exp` were just updated.
- `block_exp`  out  BFP_EXP_W  accumulated shift since `fft_start`.
- `stage_idx`  out  $clog2(FFT_N_LOG2+1)  index of the stage currently being accumulated.
- `busy`  out  1  high from `fft_start` until the `fft_done` cycle inclusive.
- `fft_done`  out  1  one-cycle pulse; `block_exp` is final.

## Operation
- FSM states: IDLE, ACCUM, UPDATE.
- **IDLE**
  - `fft_start` → ACCUM.
  - Clears `max_bw`, `block_exp`, `stage_idx` and `scale_shift` to 0.
- **ACCUM**
  - On `bw_valid`: `max_bw <= max(max_bw, min_bit_width)`.
  - On `stage_done` → UPDATE. If `bw_valid` is high in the same cycle, that sample belongs to the closing stage.
- **UPDATE** (exactly one cycle)
  - Shift rule, with T = FFT_DW-2:
    - `max_bw` ≤ T → 0.
    - `max_bw` = T+1 → 1.
    - `max_bw` ≥ T+2 → 2 (clamped).
  - Registers the shift into `scale_shift`.
  - `block_exp <= block_exp + shift`, saturating at all-ones.
  - Pulses `shift_valid` and resets `max_bw`.
  - A `bw_valid` sample arriving during UPDATE seeds the new stage's `max_bw`, so no sample is lost.
  - `stage_idx` increments. If the new value equals FFT_N_LOG2: pulse `fft_done`, `busy` falls the next cycle, → IDLE. Otherwise → ACCUM.
- **`fft_start` priority**
  - `fft_start` in any state restarts the transform: clears exponent, index and max, → ACCUM.
  - It overrides a coincident `stage_done`.
  - No `shift_valid` or `fft_done` is emitted for an aborted transform.
- **Ignored inputs**
  - `stage_done` in IDLE is ignored.
  - `bw_valid` in IDLE is ignored.
- `scale_shift` and `block_exp` hold their values between updates. `block_exp` remains readable in IDLE after `fft_done` until the next `fft_start`.

## Timing
- **Reset**: state IDLE; all outputs 0 (`scale_shift`, `shift_valid`, `block_exp`, `stage_idx`, `busy`, `fft_done`). Reset in any state aborts immediately, with no pulses.
- **Start**: `fft_start` sampled at edge E → `busy` = 1 and state ACCUM from E.
- **Stage update latency**:
  - `stage_done` sampled at edge E → UPDATE during the cycle after E.
  - New `scale_shift`/`block_exp` and `shift_valid` = 1 are visible after edge E+1, for one cycle.
  - Minimum stage length is 1 cycle; back-to-back `stage_done` one cycle after UPDATE is legal.
- **`fft_done`**: coincides with the final `shift_valid`.
- All outputs are registered; no combinational input-to-output path.

## Test plan
- Reset, then `fft_start`; stage widths 3, 14, 7, then `stage_done` → `shift_valid` 2 cycles later, `scale_shift` = 0, `block_exp` = 0, `stage_idx` = 1.
- Stage widths 9, 15 → `scale_shift` = 1, `block_exp` = 1. Next stage widths 16 → `scale_shift` = 2, `block_exp` = 3.
- Width 16 presented with `bw_valid` in the same cycle as `stage_done`, after widths of 5 → `scale_shift` = 2. A width-15 sample during UPDATE, then an immediate `stage_done` → next `scale_shift` = 1.
- Full transform with every stage at width 16 → 10 `shift_valid` pulses, `fft_done` with the 10th, `block_exp` = 20, `busy` low on the following cycle.
- `fft_start` asserted in the cycle after stage 4's `stage_done` (during UPDATE) → no `shift_valid`; `block_exp` = 0, `stage_idx` = 0, state ACCUM.
- `rst` asserted mid-stage with `max_bw` = 16 → all outputs 0 next cycle. `stage_done` while idle → no response.
